// File: rtl/hazard_unit_if.sv
// Bundle between the ID stage / pipeline control and the hazard unit.
// ID_Valid qualifies every ID_* field in the cycle it is high. There is no
// ready: Stall is the back-pressure, and it is combinational in the same cycle.
interface hazard_unit_if;
    logic        ID_Valid;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UseRs;
    logic        ID_UseRt;
    logic [4:0]  ID_Dest;
    logic        ID_RegWre;
    logic        ID_IsLoad;
    logic        Flush;
    logic        Hold;
    logic [31:0] EX_Result;
    logic [31:0] MEM_Result;
    logic        RSFwd;
    logic        RTFwd;
    logic [31:0] DataFwd;
    logic        Stall;

    // Pipeline side: drives the ID fields, controls and results.
    modport master (
        output ID_Valid, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Dest,
               ID_RegWre, ID_IsLoad, Flush, Hold, EX_Result, MEM_Result,
        input  RSFwd, RTFwd, DataFwd, Stall
    );

    // Hazard unit side.
    modport slave (
        input  ID_Valid, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Dest,
               ID_RegWre, ID_IsLoad, Flush, Hold, EX_Result, MEM_Result,
        output RSFwd, RTFwd, DataFwd, Stall
    );
endinterface

// File: rtl/hazard_unit.sv
// Operand-hazard resolver for the 5-stage MIPS pipeline, located in ID.
// Shadows the EX and MEM destinations, forwards EX/MEM results into the
// register-file read over one shared DataFwd bus, and stalls on load-use
// and on conflicts that bus cannot serve. WB hazards are left to the
// register file's own write bypass.
// Optional feature: define HAZARD_EX_FWD_EN to forward from EX. Without it,
// any EX-slot dependence stalls and only MEM results are forwarded.
module hazard_unit (
    input  logic         CLK,
    input  logic         RST,
    hazard_unit_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wre;
        logic       isLoad;
    } slot_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EX   = 2'd1,
        SRC_MEM  = 2'd2
    } src_t;

    localparam slot_t BUBBLE = '{valid: 1'b0, dest: 5'd0, wre: 1'b0, isLoad: 1'b0};

    slot_t exSlot;
    slot_t memSlot;
    slot_t exNext;

    logic  useRs;
    logic  useRt;
    src_t  rsSrc;
    src_t  rtSrc;
    src_t  fwdSrc;
    logic  exHit;
    logic  loadUse;
    logic  twoSrc;
    logic  exBlock;
    logic  stall;

    // A slot matches when it holds a real register writer of r (never $0).
    function automatic logic slotMatch(input slot_t s, input logic [4:0] r);
        return s.valid && s.wre && (s.dest != 5'd0) && (s.dest == r);
    endfunction

    // Pick a source per operand; the younger (EX) instruction wins.
    always_comb begin
        useRs = bus.ID_Valid && bus.ID_UseRs;
        useRt = bus.ID_Valid && bus.ID_UseRt;
        rsSrc = SRC_NONE;
        rtSrc = SRC_NONE;
        if (useRs) begin
            if (slotMatch(exSlot, bus.ID_Rs))       rsSrc = SRC_EX;
            else if (slotMatch(memSlot, bus.ID_Rs)) rsSrc = SRC_MEM;
        end
        if (useRt) begin
            if (slotMatch(exSlot, bus.ID_Rt))       rtSrc = SRC_EX;
            else if (slotMatch(memSlot, bus.ID_Rt)) rtSrc = SRC_MEM;
        end
    end

    // Stall on load-use, on a two-source conflict, or on any EX hit when
    // the EX forwarding path is not built.
    always_comb begin
        exHit   = (rsSrc == SRC_EX) || (rtSrc == SRC_EX);
        loadUse = exHit && exSlot.isLoad;
        twoSrc  = (rsSrc != SRC_NONE) && (rtSrc != SRC_NONE) && (rsSrc != rtSrc);
`ifdef HAZARD_EX_FWD_EN
        exBlock = 1'b0;
`else
        exBlock = exHit;
`endif
        stall   = loadUse || twoSrc || exBlock;
    end

    // Drive the register-file overrides; a stalled read gets nothing.
    always_comb begin
        fwdSrc      = (rsSrc != SRC_NONE) ? rsSrc : rtSrc;
        bus.Stall   = stall;
        bus.RSFwd   = 1'b0;
        bus.RTFwd   = 1'b0;
        bus.DataFwd = 32'd0;
        if (!stall) begin
            bus.RSFwd = (rsSrc != SRC_NONE);
            bus.RTFwd = (rtSrc != SRC_NONE);
            case (fwdSrc)
`ifdef HAZARD_EX_FWD_EN
                SRC_EX:  bus.DataFwd = bus.EX_Result;
`endif
                SRC_MEM: bus.DataFwd = bus.MEM_Result;
                default: bus.DataFwd = 32'd0;
            endcase
        end
    end

    // What enters EX: the ID instruction, or a bubble if stalled/flushed.
    always_comb begin
        exNext = BUBBLE;
        if (bus.ID_Valid && !stall && !bus.Flush) begin
            exNext.valid  = 1'b1;
            exNext.dest   = bus.ID_Dest;
            exNext.wre    = bus.ID_RegWre;
            exNext.isLoad = bus.ID_IsLoad;
        end
    end

    // Shadow pipeline advance; Hold freezes both slots, reset empties them.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exSlot  <= BUBBLE;
            memSlot <= BUBBLE;
        end else if (!bus.Hold) begin
            memSlot <= exSlot;
            exSlot  <= exNext;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed test-plan sequences followed by random
// traffic, checked through an expected-response queue against a model of
// the in-flight instruction list.
`timescale 1ns/1ps
module tb_hazard_unit;

    typedef struct {
        bit       valid;
        bit [4:0] dest;
        bit       wre;
        bit       isld;
    } rec_t;

    logic CLK;
    logic RST;
    hazard_unit_if hif();

    hazard_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (hif.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [34:0] exp_q[$];
    string       name_q[$];
    rec_t        inflight[$];

    // clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic rec_t bubble();
        rec_t r;
        r.valid = 0; r.dest = 0; r.wre = 0; r.isld = 0;
        return r;
    endfunction

    function automatic bit hits(rec_t e, bit [4:0] r);
        return e.valid && e.wre && e.dest != 0 && e.dest == r;
    endfunction

    // 0 = none, 1 = EX (youngest in flight), 2 = MEM
    function automatic int src_of(bit used, bit [4:0] r);
        if (!used) return 0;
        if (hits(inflight[0], r)) return 1;
        if (hits(inflight[1], r)) return 2;
        return 0;
    endfunction

    task automatic clear_model();
        inflight.delete();
        inflight.push_back(bubble());
        inflight.push_back(bubble());
    endtask

    task automatic check(string nm, logic [34:0] got, logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got stall=%0b rsfwd=%0b rtfwd=%0b data=%08h, expected stall=%0b rsfwd=%0b rtfwd=%0b data=%08h",
                     nm, got[34], got[33], got[32], got[31:0], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    // Drive one ID cycle, push the expected response, advance the model.
    task automatic cycle(input string nm, input bit v, input bit [4:0] rs, input bit [4:0] rt,
                         input bit urs, input bit urt, input bit [4:0] dst, input bit wre,
                         input bit ld, input bit fl, input bit hd,
                         input logic [31:0] exr, input logic [31:0] memr);
        int s_rs, s_rt, sel;
        bit stall;
        logic [31:0] data;
        rec_t nr;
        @(negedge CLK);
        hif.ID_Valid = v;   hif.ID_Rs = rs;     hif.ID_Rt = rt;
        hif.ID_UseRs = urs; hif.ID_UseRt = urt; hif.ID_Dest = dst;
        hif.ID_RegWre = wre; hif.ID_IsLoad = ld;
        hif.Flush = fl; hif.Hold = hd;
        hif.EX_Result = exr; hif.MEM_Result = memr;
        s_rs = src_of(v && urs, rs);
        s_rt = src_of(v && urt, rt);
        stall = ((s_rs == 1 || s_rt == 1) && inflight[0].isld) ||
                (s_rs != 0 && s_rt != 0 && s_rs != s_rt);
`ifndef HAZARD_EX_FWD_EN
        if (s_rs == 1 || s_rt == 1) stall = 1;
`endif
        if (stall) begin
            exp_q.push_back({1'b1, 1'b0, 1'b0, 32'd0});
        end else begin
            sel  = (s_rs != 0) ? s_rs : s_rt;
            data = (sel == 1) ? exr : (sel == 2) ? memr : 32'd0;
            exp_q.push_back({1'b0, s_rs != 0, s_rt != 0, data});
        end
        name_q.push_back(nm);
        if (!hd) begin
            nr = bubble();
            if (v && !stall && !fl) begin
                nr.valid = 1; nr.dest = dst; nr.wre = wre; nr.isld = ld;
            end
            inflight.push_front(nr);
            void'(inflight.pop_back());
        end
    endtask

    // monitor: one response per driven cycle, sampled mid-low-phase
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (exp_q.size() > 0)
                check(name_q.pop_front(), {hif.Stall, hif.RSFwd, hif.RTFwd, hif.DataFwd}, exp_q.pop_front());
        end
    end

    // stimulus
    initial begin
        int wait_cnt;
        RST = 1'b0;
        hif.ID_Valid = 1; hif.ID_Rs = 5; hif.ID_Rt = 6; hif.ID_UseRs = 1; hif.ID_UseRt = 1;
        hif.ID_Dest = 0; hif.ID_RegWre = 0; hif.ID_IsLoad = 0; hif.Flush = 0; hif.Hold = 0;
        hif.EX_Result = 32'h1111_1111; hif.MEM_Result = 32'h2222_2222;
        clear_model();
        #3;
        check("reset_held", {hif.Stall, hif.RSFwd, hif.RTFwd, hif.DataFwd}, 35'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        cycle("empty_slots", 1, 5, 6, 1, 1, 0, 0, 0, 0, 0, 32'hAAAA_0001, 32'hBBBB_0001);

        // ALU dependence through EX (or one stall then MEM without EX fwd)
        cycle("add3_issue", 1, 1, 2, 0, 0, 3, 1, 0, 0, 0, 32'h0, 32'h0);
        cycle("add3_use", 1, 3, 0, 1, 0, 10, 1, 0, 0, 0, 32'h0000_1234, 32'h0BAD_0001);
        cycle("add3_retry", 1, 3, 0, 1, 0, 10, 1, 0, 0, 0, 32'h0000_1234, 32'h0000_1234);
        cycle("drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle("drain2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // load-use
        cycle("lw4_issue", 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 32'h0, 32'h0);
        cycle("lw4_use", 1, 1, 4, 0, 1, 12, 1, 0, 0, 0, 32'hDEAD_0000, 32'h0);
        cycle("lw4_retry", 1, 1, 4, 0, 1, 12, 1, 0, 0, 0, 32'hDEAD_0000, 32'hCAFE_F00D);
        cycle("drain3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle("drain4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // two-source conflict
        cycle("w8_issue", 1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 32'h0, 32'h0);
        cycle("w7_issue", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 32'h0, 32'h0);
        cycle("two_src", 1, 7, 8, 1, 1, 13, 1, 0, 0, 0, 32'h7777_0007, 32'h8888_0008);
        cycle("two_src_retry", 1, 7, 8, 1, 1, 13, 1, 0, 0, 0, 32'h0, 32'h7777_0007);
        cycle("drain5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle("drain6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // $0 writer never forwards
        cycle("w0_issue", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        cycle("w0_use", 1, 0, 0, 1, 1, 14, 1, 0, 0, 0, 32'h5555_5555, 32'h6666_6666);
        // flushed writer never enters EX
        cycle("w11_flush", 1, 0, 0, 0, 0, 11, 1, 0, 1, 0, 32'h0, 32'h0);
        cycle("w11_use", 1, 11, 11, 1, 1, 15, 1, 0, 0, 0, 32'h1111_000B, 32'h2222_000B);
        cycle("w11_use2", 0, 11, 11, 1, 1, 15, 1, 0, 0, 0, 32'h1111_000B, 32'h2222_000B);

        // hold keeps the EX slot for 3 cycles
        cycle("w9_issue", 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            cycle("hold_w9", 1, 9, 0, 1, 0, 16, 1, 0, 0, 1, 32'h9999_0000 + i, 32'h0);
        cycle("hold_release", 1, 9, 0, 1, 0, 16, 1, 0, 0, 0, 32'h9999_1000, 32'h9999_2000);

        // reset mid-sequence, checked with no clock edge in between
        cycle("pre_reset_w9", 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 32'h0, 32'h0);
        cycle("pre_reset_use", 1, 9, 9, 1, 1, 0, 0, 0, 0, 1, 32'h1234_5678, 32'h8765_4321);
        @(negedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("async_reset", {hif.Stall, hif.RSFwd, hif.RTFwd, hif.DataFwd}, 35'd0);
        clear_model();
        @(posedge CLK);
        @(negedge CLK);
        #4;
        RST = 1'b1;

        // random traffic over a small register range so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            cycle("random",
                  $urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
                  $urandom(), $urandom());
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge CLK);
            wait_cnt++;
        end
        @(negedge CLK);
        #4;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Operand-hazard resolver for the 5-stage MIPS pipeline. It sits in ID directly upstream of the register file and drives its `RSFwd`, `RTFwd` and `DataFwd` inputs. It tracks the destination of the instructions in EX and MEM in its own shadow pipeline and forwards EX or MEM results into the operand read. It also raises `Stall` for load-use hazards and for conflicts the single shared `DataFwd` bus cannot serve. WB-stage hazards are left to the register file's internal write bypass.

## Interface
- No parameters; all widths fixed (5-bit register index, 32-bit data).
- Clock and reset:
  - `CLK` in, 1: rising-edge clock.
  - `RST` in, 1: asynchronous, active-low reset.
- ID-stage inputs:
  - `ID_Valid` in, 1: ID holds a real instruction.
  - `ID_Rs` in, 5: source register read on port 1.
  - `ID_Rt` in, 5: source register read on port 2.
  - `ID_UseRs` in, 1: ID instruction consumes Rs.
  - `ID_UseRt` in, 1: ID instruction consumes Rt.
  - `ID_Dest` in, 5: destination register of the ID instruction.
  - `ID_RegWre` in, 1: ID instruction writes a register.
  - `ID_IsLoad` in, 1: ID instruction is a load.
- Pipeline control inputs:
  - `Flush` in, 1: kill the ID instruction; a bubble enters EX.
  - `Hold` in, 1: global freeze (memory wait); shadow slots hold.
- Result inputs:
  - `EX_Result` in, 32: ALU result of the instruction in EX.
  - `MEM_Result` in, 32: final result (ALU or load data) of the instruction in MEM.
- Outputs:
  - `RSFwd` out, 1: register file substitutes `DataFwd` on read port 1.
  - `RTFwd` out, 1: register file substitutes `DataFwd` on read port 2.
  - `DataFwd` out, 32: forwarded value.
  - `Stall` out, 1: hold PC and ID, insert bubble.

## Operation
- Shadow slots EX and MEM each hold: valid, dest[4:0], wre, isload.
- A slot "matches" register r when all hold: valid, wre, dest≠0, dest==r.
- Per operand X∈{Rs,Rt}, evaluated only when `ID_Valid` and UseX are set:
  - Source EX if the EX slot matches; else MEM if the MEM slot matches; else none. The younger instruction wins.
- Stall conditions (any one raises `Stall`):
  - the EX slot matches a used operand and EX.isload=1 (load-use);
  - both operands need forwarding from different sources (single `DataFwd` bus);
  - `HAZARD_EX_FWD_EN` is not defined and the EX slot matches a used operand.
- Outputs when not stalled:
  - `RSFwd` = Rs source≠none; `RTFwd` = Rt source≠none.
  - `DataFwd` = `EX_Result` if the chosen source is EX, `MEM_Result` if MEM, else 0.
  - Rs==Rt with a common source: both flags set, one value.
- Outputs when stalled: `RSFwd`=`RTFwd`=0, `DataFwd`=0.
- `Flush` does not change `Stall`. It only changes what enters EX at the next edge.
- Slot update on rising `CLK` when `Hold`=0:
  - MEM ← EX.
  - EX ← {1, `ID_Dest`, `ID_RegWre`, `ID_IsLoad`} if `ID_Valid` and not `Stall` and not `Flush`; otherwise EX ← bubble (valid=0).
- When `Hold`=1: both slots keep their contents. Outputs remain combinational from the held slots and the current ID inputs.

## Timing
- Reset (`RST`=0, asynchronous): both slots are cleared to valid=0.
  - Hence `RSFwd`=`RTFwd`=0, `DataFwd`=0 and `Stall`=0 while reset is held and on the first cycle after release.
- Reset asserted mid-operation discards all in-flight tracking immediately, without waiting for a clock edge.
- All outputs are combinational in the ID cycle: zero-cycle latency from `ID_*`, the slots, and `EX_Result`/`MEM_Result`.
- Slot state has one cycle of latency per stage.
- Load-use costs exactly 1 stall cycle. After that edge the load is in MEM and is forwarded from `MEM_Result`.
- Two-source conflict costs 1 stall cycle. After that edge the EX instruction is in MEM and the former MEM instruction is in WB, covered by the register file bypass.
- Without EX forwarding, an ALU dependence costs 1 stall cycle.

## Configuration
- Macro: `HAZARD_EX_FWD_EN`.
- Defined: EX-stage results are forwarded as described.
- Undefined: the EX-to-ID path and the `EX_Result` mux leg are removed.
  - Any EX-slot match on a used operand stalls.
  - `EX_Result` is ignored.
  - Only MEM forwarding remains.

## Test plan
- Reset release, then an ID instruction using Rs=5 and Rt=6 with empty slots → `Stall`=0, `RSFwd`=`RTFwd`=0, `DataFwd`=0.
- `add $3` issued; next ID uses Rs=3; `EX_Result`=0x1234 → `RSFwd`=1, `DataFwd`=0x1234, `Stall`=0. With the macro undefined → `Stall`=1 for 1 cycle, then `RSFwd`=1 with `MEM_Result`.
- `lw $4` then a dependent use of Rt=4 → `Stall`=1 for exactly 1 cycle and a bubble in EX. Next cycle `RTFwd`=1, `DataFwd`=`MEM_Result`=0xCAFEF00D.
- EX writes $7, MEM writes $8, ID uses Rs=7 and Rt=8 → `Stall`=1 for 1 cycle. Next cycle `RSFwd`=1 with `MEM_Result`, `RTFwd`=0.
- Write to $0 in EX with ID Rs=0 → no forward, no stall. `Flush` with a valid ID writer → next cycle the EX slot is invalid and nothing matches.
- `Hold`=1 for 3 cycles with EX=$9 → the EX-slot forward for Rs=9 persists. `RST` pulsed mid-sequence → all outputs 0 with no clock edge.
